// File: rtl/bomba_pkg.sv
// Shared types and pot-size helpers for the multi-channel pump controller.
package bomba_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRegando,
    StPausa
  } estado_e;

  localparam logic [3:0] MacetaPequena = 4'd1;
  localparam logic [3:0] MacetaMediana = 4'd2;
  localparam logic [3:0] MacetaGrande  = 4'd3;

  // Watering multiplier for a pot-size code; 0 marks an invalid code.
  function automatic logic [1:0] tiempo_riego(input logic [3:0] code);
    case (code)
      MacetaPequena: return 2'd1;
      MacetaMediana: return 2'd2;
      MacetaGrande:  return 2'd3;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Round-robin arbiter: picks the first request after the last granted index, wrapping.
module arbitro_rr #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0] req_hi;
  logic [N-1:0] sel;
  logic         found;

  always_comb begin
    req_hi = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_hi[i] = req_i[i] && (i > 32'(last_i));
    end
    // Requests above the pointer win; otherwise wrap to the lowest index.
    sel   = (req_hi != '0) ? req_hi : req_i;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && sel[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
        found    = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bomba_multicanal.sv
// Multi-channel irrigation pump controller: latches per-pot requests, waters one pot at a
// time in round-robin order, enforces a pump-off gap and a per-pot cooldown.
module bomba_multicanal
  import bomba_pkg::*;
#(
  parameter int unsigned     N_CANALES      = 4,
  parameter longint unsigned UNIT_TICKS     = 64'd1_500_000_000,
  parameter longint unsigned DEAD_TICKS     = 64'd50_000_000,
  parameter longint unsigned COOLDOWN_TICKS = 64'd3_000_000_000,
  parameter int unsigned     CNT_W          = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MODbomba,
  input  logic [N_CANALES-1:0]         regar,
  input  logic [4*N_CANALES-1:0]       maceta,
  output logic [N_CANALES-1:0]         activarB,
  output logic                         ocupado,
  output logic [$clog2(N_CANALES):0]   canal_activo,
  output logic [N_CANALES-1:0]         fin_riego,
  output logic [N_CANALES-1:0]         error_maceta
);

  localparam int unsigned     IW     = $clog2(N_CANALES) + 1;
  localparam longint unsigned MaxCnt = {64{1'b1}} >> (64 - CNT_W);
  localparam bit ParamsOk = (N_CANALES >= 1) && (CNT_W >= 1) && (CNT_W <= 64) &&
                            (UNIT_TICKS >= 1) && (UNIT_TICKS <= MaxCnt / 3) &&
                            (DEAD_TICKS <= MaxCnt) && (COOLDOWN_TICKS <= MaxCnt);

  if (!ParamsOk) begin : g_param_check
    $error("bomba_multicanal: tick constants do not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] UnitCnt = CNT_W'(UNIT_TICKS);
  localparam logic [CNT_W-1:0] DeadCnt = CNT_W'(DEAD_TICKS);
  localparam logic [CNT_W-1:0] CoolCnt = CNT_W'(COOLDOWN_TICKS);

  estado_e              estado_q;
  logic [CNT_W-1:0]     cnt_q, dur_q;
  logic [N_CANALES-1:0] gnt_oh_q, act_q, fin_q, err_q;
  logic [IW-1:0]        last_q, canal_q;
  logic                 ocupado_q;

  logic [N_CANALES-1:0] pend, arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [3:0]           code_sel;
  logic [1:0]           mult_sel;
  logic                 fin_now, err_now;

  arbitro_rr #(
    .N  (N_CANALES),
    .IW (IW)
  ) u_arbitro (
    .req_i   (pend),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    code_sel = '0;
    for (int unsigned i = 0; i < N_CANALES; i++) begin
      if (arb_gnt[i]) code_sel = maceta[4*i +: 4];
    end
  end

  assign mult_sel = tiempo_riego(code_sel);
  assign fin_now  = MODbomba && (estado_q == StRegando) && (cnt_q == dur_q);
  assign err_now  = MODbomba && (estado_q == StIdle) && arb_valid && (mult_sel == 2'd0);

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    logic             pend_q;
    logic [CNT_W-1:0] cool_q;
    logic             servido;

    assign servido = (estado_q == StRegando) && gnt_oh_q[i];
    assign pend[i] = pend_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
        cool_q <= '0;
      end else begin
        if (fin_now && gnt_oh_q[i]) cool_q <= CoolCnt;
        else if (cool_q != '0)      cool_q <= cool_q - 1'b1;
        // Requests while served or cooling are dropped, not queued.
        if (!MODbomba || (fin_now && gnt_oh_q[i]) || (err_now && arb_gnt[i])) begin
          pend_q <= 1'b0;
        end else if (regar[i] && (cool_q == '0) && !servido) begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= StIdle;
      cnt_q     <= '0;
      dur_q     <= '0;
      gnt_oh_q  <= '0;
      last_q    <= IW'(N_CANALES - 1);
      act_q     <= '0;
      ocupado_q <= 1'b0;
      canal_q   <= '0;
      fin_q     <= '0;
      err_q     <= '0;
    end else begin
      fin_q <= '0;
      err_q <= '0;
      if (!MODbomba) begin
        estado_q  <= StIdle;
        act_q     <= '0;
        ocupado_q <= 1'b0;
        canal_q   <= '0;
      end else begin
        case (estado_q)
          StIdle: begin
            if (arb_valid) begin
              last_q <= arb_idx;
              if (err_now) begin
                err_q <= arb_gnt;
              end else begin
                estado_q  <= StRegando;
                cnt_q     <= CNT_W'(1);
                dur_q     <= CNT_W'(mult_sel) * UnitCnt;
                gnt_oh_q  <= arb_gnt;
                act_q     <= arb_gnt;
                ocupado_q <= 1'b1;
                canal_q   <= arb_idx;
              end
            end
          end
          StRegando: begin
            if (fin_now) begin
              act_q   <= '0;
              fin_q   <= gnt_oh_q;
              canal_q <= '0;
              cnt_q   <= CNT_W'(1);
              if (DEAD_TICKS == 0) begin
                estado_q  <= StIdle;
                ocupado_q <= 1'b0;
              end else begin
                estado_q <= StPausa;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StPausa: begin
            if (cnt_q >= DeadCnt) begin
              estado_q  <= StIdle;
              ocupado_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: estado_q <= StIdle;
        endcase
      end
    end
  end

  assign activarB     = act_q;
  assign ocupado      = ocupado_q;
  assign canal_activo = canal_q;
  assign fin_riego    = fin_q;
  assign error_maceta = err_q;

endmodule

// File: tb/tb_bomba_multicanal.sv
// Bench for bomba_multicanal: directed scenarios plus random traffic, all against a
// cycle model built from the watering/cooldown rules.
module tb_bomba_multicanal;

  localparam int NC   = 4;
  localparam int UNIT = 10;
  localparam int DEAD = 3;
  localparam int COOL = 20;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mod = 1'b0;
  logic [NC-1:0] regar = '0;
  logic [4*NC-1:0] maceta = '0;
  logic [NC-1:0] activarB, fin_riego, error_maceta;
  logic          ocupado;
  logic [2:0]    canal_activo;
  logic [15:0]   obs;

  int checks = 0;
  int errors = 0;

  bomba_multicanal #(
    .N_CANALES      (NC),
    .UNIT_TICKS     (UNIT),
    .DEAD_TICKS     (DEAD),
    .COOLDOWN_TICKS (COOL),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .MODbomba     (mod),
    .regar        (regar),
    .maceta       (maceta),
    .activarB     (activarB),
    .ocupado      (ocupado),
    .canal_activo (canal_activo),
    .fin_riego    (fin_riego),
    .error_maceta (error_maceta)
  );

  always #5 clk = ~clk;

  assign obs = {activarB, ocupado, canal_activo, fin_riego, error_maceta};

  // Reference model: phase 0 idle, 1 watering channel m_ch, 2 pump-off gap.
  bit          m_pend[NC];
  int          m_cool[NC];
  int          m_phase, m_ch, m_left, m_pause, m_last;
  logic [15:0] exp_vec;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_pend[i] = 1'b0;
      m_cool[i] = 0;
    end
    m_phase = 0; m_ch = 0; m_left = 0; m_pause = 0; m_last = NC - 1;
    exp_vec = '0;
  endtask

  task automatic model_step();
    int fin_ch, err_ch, g, code, old_phase, old_ch;
    int old_cool[NC];
    bit old_pend[NC];
    logic [3:0] act_e, fin_e, err_e;
    fin_ch = -1; err_ch = -1; old_phase = m_phase; old_ch = m_ch;
    for (int i = 0; i < NC; i++) begin
      old_cool[i] = m_cool[i];
      old_pend[i] = m_pend[i];
    end
    if (!mod) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      g = -1;
      for (int k = 1; k <= NC; k++) begin
        if (g < 0 && old_pend[(m_last + k) % NC]) g = (m_last + k) % NC;
      end
      if (g >= 0) begin
        code   = int'(maceta[4*g +: 4]);
        m_last = g;
        if (code < 1 || code > 3) err_ch = g;
        else begin
          m_phase = 1; m_ch = g; m_left = code * UNIT;
        end
      end
    end else if (m_phase == 1) begin
      if (m_left == 1) begin
        fin_ch = m_ch; m_pause = DEAD; m_phase = (DEAD == 0) ? 0 : 2;
      end else begin
        m_left--;
      end
    end else begin
      m_pause--;
      if (m_pause == 0) m_phase = 0;
    end
    for (int i = 0; i < NC; i++) begin
      if (!mod || i == fin_ch || i == err_ch) m_pend[i] = 1'b0;
      else if (regar[i] && old_cool[i] == 0 && !(old_phase == 1 && old_ch == i)) m_pend[i] = 1'b1;
      if (i == fin_ch) m_cool[i] = COOL;
      else if (m_cool[i] > 0) m_cool[i]--;
    end
    act_e = (m_phase == 1) ? 4'(1 << m_ch) : 4'b0;
    fin_e = (fin_ch >= 0) ? 4'(1 << fin_ch) : 4'b0;
    err_e = (err_ch >= 0) ? 4'(1 << err_ch) : 4'b0;
    exp_vec = {act_e, (m_phase != 0), (m_phase == 1) ? 3'(m_ch) : 3'b0, fin_e, err_e};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mod = 1'b1; regar = '1; maceta = 16'h1111;
    tick(); tick();
    checks++;
    if (obs !== 16'h0) begin
      errors++; $display("FAIL reset: outputs %h required 0000", obs);
    end
    rst = 1'b0; regar = '0;
    for (int t = 0; t < 5; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL reset_idle cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
    end
  endtask

  task automatic test_all_at_once();
    int order[$];
    int overlap = 0;
    logic [NC-1:0] prev = '0;
    maceta = 16'h1111; regar = 4'b1111;
    tick(); regar = '0;
    for (int t = 0; t < 85; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL all cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
      if ($countones(activarB) > 1) overlap++;
      if (activarB != '0 && prev == '0) begin
        for (int i = 0; i < NC; i++) if (activarB[i]) order.push_back(i);
      end
      prev = activarB;
    end
    checks++;
    if (overlap != 0) begin
      errors++; $display("FAIL all_onehot: overlap cycles %0d required 0", overlap);
    end
    checks++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3)
    begin
      errors++; $display("FAIL all_order: got %p required 0,1,2,3", order);
    end
  endtask

  task automatic test_single();
    int on_cnt = 0, fin_cnt = 0, busy_after = 0;
    bit seen_fin = 1'b0;
    maceta = 16'h0002; regar = 4'b0001;
    tick(); regar = '0;
    for (int t = 0; t < 60; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL single cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
      if (activarB == 4'b0001) on_cnt++;
      if (fin_riego == 4'b0001) begin
        fin_cnt++; seen_fin = 1'b1;
      end
      if (seen_fin && ocupado) busy_after++;
    end
    checks++;
    if (on_cnt != 2 * UNIT) begin
      errors++; $display("FAIL single_on: %0d clks required %0d", on_cnt, 2 * UNIT);
    end
    checks++;
    if (fin_cnt != 1) begin
      errors++; $display("FAIL single_fin: %0d pulses required 1", fin_cnt);
    end
    checks++;
    if (busy_after != DEAD) begin
      errors++; $display("FAIL single_pause: ocupado %0d clks required %0d", busy_after, DEAD);
    end
  endtask

  task automatic test_cooldown();
    int rises = 0, fin_t = -1, rise2_t = -1;
    logic prev = 1'b0;
    maceta = 16'h0001; regar = 4'b0001;
    for (int t = 0; t < 110; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL cooldown cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
      if (fin_riego[0] && fin_t < 0) fin_t = t;
      if (activarB[0] && !prev) begin
        rises++;
        if (rises == 2) begin
          rise2_t = t; regar = '0;
        end
      end
      prev = activarB[0];
    end
    checks++;
    if (rises != 2 || rise2_t - fin_t < COOL || rise2_t - fin_t > COOL + 2) begin
      errors++;
      $display("FAIL cooldown_regrant: rises %0d gap %0d required 2 rises gap %0d..%0d",
               rises, rise2_t - fin_t, COOL, COOL + 2);
    end
  endtask

  task automatic test_invalid();
    int codes[2] = '{0, 7};
    foreach (codes[c]) begin
      int err2 = 0, act2 = 0, act3 = 0;
      maceta = {4'h1, 4'(codes[c]), 4'h1, 4'h1};
      regar = 4'b1100;
      tick(); regar = '0;
      for (int t = 0; t < 45; t++) begin
        tick(); checks++;
        if (obs !== exp_vec) begin
          errors++; $display("FAIL invalid cyc%0d: outputs %h required %h", t, obs, exp_vec);
        end
        if (error_maceta == 4'b0100) err2++;
        if (activarB[2]) act2++;
        if (activarB[3]) act3++;
      end
      checks++;
      if (err2 != 1 || act2 != 0 || act3 != UNIT) begin
        errors++;
        $display("FAIL invalid_code%0d: err %0d on2 %0d on3 %0d required 1 0 %0d",
                 codes[c], err2, act2, act3, UNIT);
      end
    end
  endtask

  task automatic test_abort_and_reset();
    int fin_cnt = 0, act_cnt = 0;
    maceta = 16'h0130; regar = 4'b0010;
    tick(); regar = '0;
    for (int t = 0; t < 5; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL abort_run cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
      regar = (t == 1) ? 4'b0100 : 4'b0000;
    end
    mod = 1'b0;
    tick(); checks++;
    if (activarB !== 4'b0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL abort_drop: activarB %b ocupado %b required 0000 0", activarB, ocupado);
    end
    tick();
    mod = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL abort_after cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
      if (fin_riego != '0) fin_cnt++;
      if (activarB != '0) act_cnt++;
    end
    checks++;
    if (fin_cnt != 0 || act_cnt != 0) begin
      errors++; $display("FAIL abort_cleared: fin %0d on %0d required 0 0", fin_cnt, act_cnt);
    end
    maceta = 16'h0003; regar = 4'b0001;
    tick(); regar = '0;
    for (int t = 0; t < 4; t++) tick();
    #3 rst = 1'b1;
    #1 checks++;
    if (obs !== 16'h0) begin
      errors++; $display("FAIL async_reset: outputs %h required 0000", obs);
    end
    tick(); tick();
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL post_reset cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
    end
  endtask

  task automatic test_maceta_change();
    int on_cnt = 0;
    maceta = 16'h0010; regar = 4'b0010;
    tick(); regar = '0;
    for (int t = 0; t < 40; t++) begin
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL size_change cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
      if (activarB[1]) on_cnt++;
      if (t == 3) maceta[7:4] = 4'h3;
    end
    checks++;
    if (on_cnt != UNIT) begin
      errors++; $display("FAIL size_change_on: %0d clks required %0d", on_cnt, UNIT);
    end
  endtask

  task automatic test_random();
    int c, code;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NC; i++) regar[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        c    = $urandom_range(0, NC - 1);
        code = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 3);
        maceta[4*c +: 4] = 4'(code);
      end
      mod = ($urandom_range(0, 199) != 0);
      tick(); checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL random cyc%0d: outputs %h required %h", t, obs, exp_vec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_at_once();
    test_single();
    test_cooldown();
    test_invalid();
    test_abort_and_reset();
    test_maceta_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
